// File: rtl/dut_bus_pkg.sv
// rtl/dut_bus_pkg.sv - shared types and constants for the dut command front end
// Contents: ADDR_W, WAIT_W, op_e (OP_WRITE/OP_READ), state_e (IDLE/ISSUE/RESP), cmd_t {op, addr, data}
package dut_bus_pkg;

   localparam int ADDR_W = 3;
   localparam int WAIT_W = 16;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] addr;
      logic              data;
   } cmd_t;

endpackage

// File: rtl/dut_cmd_fifo.sv
// rtl/dut_cmd_fifo.sv - synchronous FIFO of command structs
// Ports: clk, rst_n (async active-low), push/push_cmd (write side),
//        pop/head (read side, head is the oldest entry), full, empty
module dut_cmd_fifo
   import dut_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  cmd_t push_cmd,
   input  logic pop,
   output cmd_t head,
   output logic full,
   output logic empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   cmd_t             mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[PTR_W-1:0]] <= push_cmd;
      end
   end

endmodule

// File: rtl/dut_cmd_master.sv
// rtl/dut_cmd_master.sv - command sequencer driving the dut write/read method ports
// Ports: CLK, RST_N (async active-low)
//        cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data : command input stream
//        rsp_valid/rsp_ready/rsp_addr/rsp_data/rsp_err : response output stream
//        write_address/write_data/write_en/write_rdy   : dut write method
//        read_address/read_en/read_data/read_rdy       : dut read method
//        busy : FIFO non-empty or a command in flight
module dut_cmd_master
   import dut_bus_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] write_address,
   output logic              write_data,
   output logic              write_en,
   input  logic              write_rdy,
   output logic [ADDR_W-1:0] read_address,
   output logic              read_en,
   input  logic              read_data,
   input  logic              read_rdy,
   output logic              busy
);

   localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

   state_e            state;
   state_e            state_n;
   cmd_t              cur;
   cmd_t              head;
   cmd_t              push_cmd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              done;
   logic              tmo;
   logic [WAIT_W-1:0] wait_cnt;

   // Gated by RST_N so the source sees no readiness while reset is held.
   assign cmd_ready = ~fifo_full & RST_N;
   assign push      = cmd_valid & cmd_ready;
   assign push_cmd  = '{op: op_e'(cmd_op), addr: cmd_addr, data: cmd_data};

   dut_cmd_fifo #(
      .DEPTH(CMD_DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (push),
      .push_cmd (push_cmd),
      .pop      (pop),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // The dut-facing address/data follow the current command, so they hold
   // the last issued values whenever no command is in ISSUE.
   assign write_address = cur.addr;
   assign read_address  = cur.addr;
   assign write_data    = cur.data;
   assign rsp_valid     = (state == RESP);
   assign busy          = ~fifo_empty | (state != IDLE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      pop      = 1'b0;
      done     = 1'b0;
      tmo      = 1'b0;
      write_en = 1'b0;
      read_en  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (cur.op == OP_WRITE) begin
               write_en = write_rdy;
               done     = write_rdy;
            end else begin
               read_en = read_rdy;
               done    = read_rdy;
            end
            // A rdy arriving in the final wait cycle still wins over the abort.
            if (done) begin
               state_n = RESP;
            end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT)) begin
               tmo     = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_n = ISSUE;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cur      <= '{op: OP_WRITE, addr: '0, data: 1'b0};
         wait_cnt <= '0;
         rsp_addr <= '0;
         rsp_data <= 1'b0;
         rsp_err  <= 1'b0;
      end else begin
         if (pop) begin
            cur      <= head;
            wait_cnt <= '0;
         end else if ((state == ISSUE) && !done) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (done) begin
            rsp_addr <= cur.addr;
            rsp_data <= (cur.op == OP_READ) ? read_data : 1'b0;
            rsp_err  <= 1'b0;
         end else if (tmo) begin
            rsp_addr <= cur.addr;
            rsp_data <= 1'b0;
            rsp_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dut_cmd_master.sv
// tb/tb_dut_cmd_master.sv - directed self-checking bench for dut_cmd_master
module tb_dut_cmd_master;

   logic       CLK;
   logic       RST_N;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_op;
   logic [2:0] cmd_addr;
   logic       cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [2:0] rsp_addr;
   logic       rsp_data;
   logic       rsp_err;
   logic [2:0] write_address;
   logic       write_data;
   logic       write_en;
   logic       write_rdy;
   logic [2:0] read_address;
   logic       read_en;
   logic       read_data;
   logic       read_rdy;
   logic       busy;

   int checks;
   int failures;
   int en_cnt;
   int idx;
   int rsp_cnt;

   dut_cmd_master #(
      .CMD_DEPTH (4),
      .TIMEOUT   (8)
   ) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_addr      (cmd_addr),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_addr      (rsp_addr),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .write_address (write_address),
      .write_data    (write_data),
      .write_en      (write_en),
      .write_rdy     (write_rdy),
      .read_address  (read_address),
      .read_en       (read_en),
      .read_data     (read_data),
      .read_rdy      (read_rdy),
      .busy          (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge; checks follow 1 time unit later.
   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic set_cmd(input logic v, input logic op, input logic [2:0] a, input logic d);
      cmd_valid = v;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      RST_N     = 1'b0;
      set_cmd(1'b0, 1'b0, 3'd0, 1'b0);
      rsp_ready = 1'b0;
      write_rdy = 1'b0;
      read_rdy  = 1'b0;
      read_data = 1'b0;

      // Reset state
      cyc(); #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_addr", rsp_addr, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_en", {write_en, read_en}, 0);
      chk("rst_addr", {write_address, read_address, write_data}, 0);
      chk("rst_busy", busy, 0);
      cyc(); RST_N = 1'b1; #1;
      chk("rel_cmd_ready", cmd_ready, 1);

      // Single write: push in cycle 0, enable in cycle 2, response in cycle 3
      cyc(); set_cmd(1'b1, 1'b0, 3'd4, 1'b1); write_rdy = 1'b1; rsp_ready = 1'b1; #1;
      chk("w_c0_en", write_en, 0);
      cyc(); set_cmd(1'b0, 1'b0, 3'd0, 1'b0); #1;
      chk("w_c1_en", write_en, 0);
      chk("w_c1_busy", busy, 1);
      cyc(); #1;
      chk("w_c2_en", write_en, 1);
      chk("w_c2_addr", write_address, 4);
      chk("w_c2_data", write_data, 1);
      chk("w_c2_rden", read_en, 0);
      cyc(); #1;
      chk("w_c3_en", write_en, 0);
      chk("w_c3_rsp", {rsp_valid, rsp_addr, rsp_data, rsp_err}, {1'b1, 3'd4, 1'b0, 1'b0});
      cyc(); write_rdy = 1'b0; #1;
      chk("w_c4_idle", {busy, rsp_valid}, 0);

      // Stalled read: read_rdy low for 5 ISSUE cycles, then high for one
      cyc(); set_cmd(1'b1, 1'b1, 3'd3, 1'b0); read_data = 1'b1; #1;
      cyc(); set_cmd(1'b0, 1'b0, 3'd0, 1'b0); #1;
      en_cnt = 0;
      for (int i = 2; i <= 7; i++) begin
         cyc(); read_rdy = (i == 7); #1;
         if (read_en) en_cnt++;
         chk("sr_wr_en", write_en, 0);
      end
      cyc(); read_rdy = 1'b0; #1;
      if (read_en) en_cnt++;
      chk("sr_en_cnt", en_cnt, 1);
      chk("sr_rsp", {rsp_valid, rsp_addr, rsp_data, rsp_err}, {1'b1, 3'd3, 1'b1, 1'b0});
      cyc(); #1;
      chk("sr_idle", {busy, rsp_valid}, 0);

      // Timeout: ISSUE entered in cycle 2, response 9 cycles later
      cyc(); set_cmd(1'b1, 1'b1, 3'd0, 1'b0); read_data = 1'b1; #1;
      en_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc(); if (i == 1) set_cmd(1'b0, 1'b0, 3'd0, 1'b0); #1;
         if (read_en || write_en) en_cnt++;
         chk("to_wait_rsp", rsp_valid, 0);
      end
      cyc(); #1;
      chk("to_en_cnt", en_cnt, 0);
      chk("to_rsp", {rsp_valid, rsp_addr, rsp_data, rsp_err}, {1'b1, 3'd0, 1'b0, 1'b1});
      cyc(); read_data = 1'b0; #1;
      chk("to_idle", busy, 0);

      // FIFO full: 7 writes offered back-to-back with responses blocked
      rsp_ready = 1'b0;
      write_rdy = 1'b1;
      read_rdy  = 1'b1;
      idx = 1;
      for (int i = 0; i <= 6; i++) begin
         cyc(); set_cmd(1'b1, 1'b0, 3'(idx), 1'(idx)); #1;
         chk("ff_ready", cmd_ready, (i < 5) ? 1 : 0);
         chk("ff_wen", write_en, (i == 2) ? 1 : 0);
         if (cmd_ready) idx++;
      end
      chk("ff_accepted", idx - 1, 5);
      chk("ff_rsp_hold", {rsp_valid, rsp_addr}, {1'b1, 3'd1});
      rsp_cnt = 0;
      for (int i = 0; i < 40 && rsp_cnt < 7; i++) begin
         cyc();
         rsp_ready = 1'b1;
         if (idx <= 7) set_cmd(1'b1, 1'b0, 3'(idx), 1'(idx));
         else          set_cmd(1'b0, 1'b0, 3'd0, 1'b0);
         #1;
         if (rsp_valid) begin
            rsp_cnt++;
            chk("ff_rsp_order", {rsp_addr, rsp_data, rsp_err}, {3'(rsp_cnt), 1'b0, 1'b0});
         end
         if (cmd_valid && cmd_ready) idx++;
      end
      chk("ff_rsp_cnt", rsp_cnt, 7);
      cyc(); set_cmd(1'b0, 1'b0, 3'd0, 1'b0); #1;
      chk("ff_idle", busy, 0);

      // Response back-pressure: two writes queued, response held 10 cycles
      rsp_ready = 1'b0;
      read_rdy  = 1'b0;
      cyc(); set_cmd(1'b1, 1'b0, 3'd5, 1'b1); #1;
      cyc(); set_cmd(1'b1, 1'b0, 3'd6, 1'b0); #1;
      cyc(); set_cmd(1'b0, 1'b0, 3'd0, 1'b0); #1;
      chk("bp_a_en", {write_en, write_address, write_data}, {1'b1, 3'd5, 1'b1});
      for (int i = 3; i <= 12; i++) begin
         cyc(); #1;
         chk("bp_hold", {rsp_valid, rsp_addr, rsp_data, rsp_err, write_en}, {1'b1, 3'd5, 1'b0, 1'b0, 1'b0});
      end
      cyc(); rsp_ready = 1'b1; #1;
      chk("bp_a_rsp", {rsp_valid, rsp_addr}, {1'b1, 3'd5});
      cyc(); #1;
      chk("bp_b_en", {write_en, write_address, write_data, rsp_valid}, {1'b1, 3'd6, 1'b0, 1'b0});
      cyc(); #1;
      chk("bp_b_rsp", {rsp_valid, rsp_addr, rsp_err}, {1'b1, 3'd6, 1'b0});
      cyc(); #1;
      chk("bp_idle", busy, 0);

      // Reset mid-ISSUE with a second command still queued
      cyc(); set_cmd(1'b1, 1'b0, 3'd2, 1'b1); #1;
      cyc(); set_cmd(1'b1, 1'b0, 3'd7, 1'b0); #1;
      cyc(); set_cmd(1'b0, 1'b0, 3'd0, 1'b0); #1;
      chk("rm_en", {write_en, write_address}, {1'b1, 3'd2});
      RST_N = 1'b0; #1;
      chk("rm_en_drop", {write_en, rsp_valid, cmd_ready}, 0);
      cyc(); RST_N = 1'b1; #1;
      chk("rm_rel", {busy, rsp_valid, cmd_ready}, {1'b0, 1'b0, 1'b1});
      en_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         if (rsp_valid || write_en) en_cnt++;
      end
      chk("rm_quiet", en_cnt, 0);
      cyc(); set_cmd(1'b1, 1'b1, 3'd6, 1'b0); read_rdy = 1'b1; read_data = 1'b1; #1;
      cyc(); set_cmd(1'b0, 1'b0, 3'd0, 1'b0); #1;
      cyc(); #1;
      chk("rm_ren", {read_en, read_address, write_en}, {1'b1, 3'd6, 1'b0});
      cyc(); #1;
      chk("rm_rsp", {rsp_valid, rsp_addr, rsp_data, rsp_err}, {1'b1, 3'd6, 1'b1, 1'b0});
      cyc(); #1;
      chk("rm_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dut_cmd_master.md
# dut_cmd_master

Command sequencer that sits directly upstream of the `dut` register/FIFO block. It accepts a stream of write/read commands on a valid/ready port and buffers them in a small FIFO. It issues each command, one at a time, on the `dut` enable/ready method ports, and returns one response per command (read data or timeout error) on a valid/ready port. It is the standard front end for driving `dut` from a bus or a test sequencer.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `TIMEOUT`, 255: maximum cycles to wait for `*_rdy` before aborting; range 0..65535; 0 disables the timeout.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command FIFO not full.
- `cmd_op`  in  1  0 = write, 1 = read.
- `cmd_addr`  in  3  target address.
- `cmd_data`  in  1  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_addr`  out  3  address of the completed command.
- `rsp_data`  out  1  read data; 0 for writes and for errors.
- `rsp_err`  out  1  1 = command aborted by timeout.
- `write_address`  out  3  to `dut`.
- `write_data`  out  1  to `dut`.
- `write_en`  out  1  to `dut`.
- `write_rdy`  in  1  from `dut`.
- `read_address`  out  3  to `dut`.
- `read_en`  out  1  to `dut`.
- `read_data`  in  1  from `dut`; valid in the cycle `read_en` is high.
- `read_rdy`  in  1  from `dut`.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- A command is pushed when `cmd_valid & cmd_ready`. `cmd_ready = ~fifo_full`, forced to 0 while `RST_N` is low. Push-while-full is never accepted, even when a pop occurs in the same cycle.
- **IDLE**: if the FIFO is non-empty, pop the head into the current-command registers and go to ISSUE.
- **ISSUE**: drive `*_address` and `write_data` from the current-command registers.
  - For a write: `write_en = write_rdy`. For a read: `read_en = read_rdy`.
  - An enable is never high without its rdy, and only the enable matching the current op is ever asserted.
  - On the cycle the enable is high, the transaction completes. For a read, `read_data` is captured into the response register. Go to RESP with `rsp_err=0`.
  - While rdy is low, the wait counter increments. When it reaches `TIMEOUT` (and `TIMEOUT≠0`), go to RESP with `rsp_err=1` and `rsp_data=0`; no enable is issued.
  - The wait counter clears on entry to ISSUE.
- **RESP**: `rsp_valid=1`. All `rsp_*` fields stay stable until `rsp_ready`. On the handshake:
  - if the FIFO is non-empty, pop directly into ISSUE;
  - otherwise go to IDLE.
- Responses are returned strictly in command order. Exactly one response is produced per accepted command.
- `write_address`/`read_address`/`write_data` hold the last issued values outside ISSUE; they are meaningful only when an enable is high.

## Timing
- Reset values: state IDLE; FIFO empty; `cmd_ready=0` while reset is asserted and 1 after release; `rsp_valid=0`; `rsp_addr=0`; `rsp_data=0`; `rsp_err=0`; `write_en=0`; `read_en=0`; `write_address=0`; `read_address=0`; `write_data=0`; `busy=0`.
- Latency with rdy held high:
  - push in cycle 0;
  - pop at the end of cycle 1;
  - enable in cycle 2;
  - `rsp_valid` in cycle 3.
- Throughput: one command per 2 cycles when `rsp_ready` is held high.
- Timeout: `rsp_valid` rises `TIMEOUT+1` cycles after entry to ISSUE if rdy stays low.
- Reset mid-operation takes effect asynchronously:
  - enables and `rsp_valid` drop immediately;
  - FIFO contents and the in-flight command are discarded;
  - no response is emitted after release.

## Structure
- Package `dut_bus_pkg` holds:
  - `ADDR_W=3`;
  - op enum `OP_WRITE=0`, `OP_READ=1`;
  - state enum `IDLE`/`ISSUE`/`RESP`;
  - a packed command struct {op, addr, data}.
- Sub-module `dut_cmd_fifo`: synchronous FIFO of command structs, `CMD_DEPTH` entries, with full/empty flags and an async active-low reset.
- The wait counter is 16 bits.

## Test plan
- **Single write**: push write addr 4 data 1 with `write_rdy=1` → `write_en` high only in cycle 2 with `write_address=4`, `write_data=1`; `rsp_valid` in cycle 3 with addr 4, data 0, err 0.
- **Stalled read**: push read addr 3 with `read_rdy=0` for 5 cycles, then 1, and `read_data=1` → `read_en` high for exactly 1 cycle; response addr 3, data 1, err 0.
- **Timeout**: `TIMEOUT=8`, read addr 0, `read_rdy` never high → `read_en` never asserted; `rsp_valid` 9 cycles after ISSUE entry with err 1, data 0.
- **FIFO full**: `CMD_DEPTH=4`, `rsp_ready=0`, rdy high, push 7 commands back-to-back → 5 accepted (1 in RESP, 4 buffered), `cmd_ready` low thereafter. Releasing `rsp_ready` yields 5 in-order responses, and the remaining pushes are accepted as space frees.
- **Response back-pressure**: `rsp_ready=0` for 10 cycles with 2 commands queued → `rsp_*` stable, no further enables; responses drain in order after release.
- **Reset mid-ISSUE**: drop `RST_N` in the cycle `write_en` is high → `write_en` falls immediately; after release `busy=0`, `rsp_valid=0`, and a new command completes normally.
